syscall_io_ctrl: RTL

- Sequences the syscall datapath. Detects a syscall in the writeback-feeding stage and stalls the pipeline.
- Runs a valid/ready handshake with the external console for INPUT_INT and PRINT_INT, or halts the core on EXIT.
- Drives `sys_in` into the register-source mux and the stall line into the hazard/pipeline-register enables.

---
 rtl/syscall_io_ctrl_pkg.sv | 33 +++
 rtl/syscall_io_ctrl_if.sv | 38 +++
 rtl/syscall_io_ctrl_timer.sv | 30 +++
 rtl/syscall_io_ctrl.sv | 103 ++++++++++
 4 files changed

// File: rtl/syscall_io_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : syscall_io_ctrl_pkg
// Purpose  : Shared syscall op codes, op-code width and controller state
//            encodings for the syscall datapath.
// Revision : 1.0 - initial release
// ============================================================================
package syscall_io_ctrl_pkg;

  // Syscall op code arrives in $v0, so it is a full register wide.
  localparam int SYS_OP_LENGTH = 32;

  localparam logic [SYS_OP_LENGTH-1:0] SYSCALL_PRINT_INT = 32'd1;
  localparam logic [SYS_OP_LENGTH-1:0] SYSCALL_INPUT_INT = 32'd5;
  localparam logic [SYS_OP_LENGTH-1:0] SYSCALL_EXIT      = 32'd10;

  localparam int STATE_W = 3;
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_IN_WAIT  = 3'd1;
  localparam state_t ST_OUT_WAIT = 3'd2;
  localparam state_t ST_DONE     = 3'd3;
  localparam state_t ST_HALT     = 3'd4;

  // True for op codes the controller acts on; anything else is a no-op.
  function automatic logic is_known_op(input logic [SYS_OP_LENGTH-1:0] op);
    return (op == SYSCALL_PRINT_INT) || (op == SYSCALL_INPUT_INT) ||
           (op == SYSCALL_EXIT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/syscall_io_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : syscall_io_ctrl_if
// Purpose  : Pipeline and console signals of the syscall controller.
//            master = controller side, slave = pipeline/console side.
// Revision : 1.0 - initial release
// ============================================================================
interface syscall_io_ctrl_if
  import syscall_io_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
);
  logic                     syscall;
  logic [SYS_OP_LENGTH-1:0] sys_op;
  logic [DATA_W-1:0]        a0_data;
  logic                     stall;
  logic [DATA_W-1:0]        sys_in;
  logic                     sys_done;
  logic                     in_req;
  logic                     in_ack;
  logic [DATA_W-1:0]        in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_W-1:0]        out_data;
  logic                     halted;
  logic                     timeout;

  modport master (
    input  syscall, sys_op, a0_data, in_ack, in_data, out_ready,
    output stall, sys_in, sys_done, in_req, out_valid, out_data, halted, timeout
  );

  modport slave (
    output syscall, sys_op, a0_data, in_ack, in_data, out_ready,
    input  stall, sys_in, sys_done, in_req, out_valid, out_data, halted, timeout
  );
endinterface
`default_nettype wire

// File: rtl/syscall_io_ctrl_timer.sv
`default_nettype none
// ============================================================================
// Module   : syscall_timer
// Purpose  : Handshake wait counter. Cleared while not waiting, counts each
//            waiting cycle, flags expiry on the CYCLES-th waiting cycle.
// Revision : 1.0 - initial release
// ============================================================================
module syscall_timer #(
  parameter int CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic [CNT_W-1:0] r_count;

  // Wait-cycle counter; expiry ends the wait, so wrap-around is never reached.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_count <= '0;
    else if (clear)  r_count <= '0;
    else if (enable) r_count <= r_count + 1'b1;
  end

  assign expired = enable && (r_count == CNT_W'(CYCLES - 1));
endmodule
`default_nettype wire

// File: rtl/syscall_io_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : syscall_io_ctrl
// Purpose  : Syscall sequencer. Stalls the pipeline on a syscall, runs the
//            console valid/ready handshake for INPUT_INT / PRINT_INT and halts
//            the core on EXIT.
// Options  : SYSCALL_TIMEOUT_EN - bound each handshake wait to TIMEOUT_CYCLES.
// Revision : 1.0 - initial release
// ============================================================================
module syscall_io_ctrl
  import syscall_io_ctrl_pkg::*;
#(
  parameter int                DATA_W         = 32,
  parameter int                TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_W-1:0] TIMEOUT_VALUE  = 32'hFFFF_FFFF
) (
  input  logic               clk,
  input  logic               rst,
  syscall_io_ctrl_if.master  bus
);
  state_t            r_state;
  state_t            w_next_state;
  logic [DATA_W-1:0] r_sys_in;
  logic [DATA_W-1:0] r_out_data;
  logic              w_waiting;
  logic              w_expired;

  assign w_waiting = (r_state == ST_IN_WAIT) || (r_state == ST_OUT_WAIT);

`ifdef SYSCALL_TIMEOUT_EN
  syscall_timer #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (!w_waiting),
    .enable  (w_waiting),
    .expired (w_expired)
  );
`else
  // No timer: waits are unbounded; timeout settings are unused here.
  logic w_unused_cfg;
  assign w_unused_cfg = ^{TIMEOUT_CYCLES, TIMEOUT_VALUE};
  assign w_expired    = 1'b0;
`endif

  // State register; reset abandons any transfer immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic; syscall is only sampled in IDLE so DONE cannot retrigger.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.syscall) begin
          if      (bus.sys_op == SYSCALL_INPUT_INT) w_next_state = ST_IN_WAIT;
          else if (bus.sys_op == SYSCALL_PRINT_INT) w_next_state = ST_OUT_WAIT;
          else if (bus.sys_op == SYSCALL_EXIT)      w_next_state = ST_HALT;
        end
      end
      ST_IN_WAIT:  if (bus.in_ack || w_expired)    w_next_state = ST_DONE;
      ST_OUT_WAIT: if (bus.out_ready || w_expired) w_next_state = ST_DONE;
      ST_DONE:     w_next_state = ST_IDLE;
      ST_HALT:     w_next_state = ST_HALT;
      default:     w_next_state = ST_IDLE;
    endcase
  end

  // Outputs; stall is combinational so a syscall freezes before its first edge.
  always_comb begin
    bus.stall     = ((r_state == ST_IDLE) && bus.syscall && is_known_op(bus.sys_op)) ||
                    w_waiting || (r_state == ST_HALT);
    bus.in_req    = (r_state == ST_IN_WAIT);
    bus.out_valid = (r_state == ST_OUT_WAIT);
    bus.sys_done  = (r_state == ST_DONE);
    bus.halted    = (r_state == ST_HALT);
    // A handshake in the expiry cycle takes priority over the timeout.
    bus.timeout   = w_expired &&
                    (((r_state == ST_IN_WAIT)  && !bus.in_ack) ||
                     ((r_state == ST_OUT_WAIT) && !bus.out_ready));
    bus.sys_in    = r_sys_in;
    bus.out_data  = r_out_data;
  end

  // Data registers: input word (held between syscalls) and word to print.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sys_in   <= '0;
      r_out_data <= '0;
    end else begin
      if (r_state == ST_IN_WAIT) begin
        if (bus.in_ack)     r_sys_in <= bus.in_data;
        else if (w_expired) r_sys_in <= TIMEOUT_VALUE;
      end
      if ((r_state == ST_IDLE) && bus.syscall && (bus.sys_op == SYSCALL_PRINT_INT))
        r_out_data <= bus.a0_data;
    end
  end
endmodule
`default_nettype wire
